// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty compare,
// double-buffered period/duty/mode that switch over only at a period boundary.
module pwm_multichannel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic                      center_mode,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_end,
  output logic                      load_ack
);

  logic [WIDTH-1:0]          cnt;
  logic                      dir;        // 0 = counting up, 1 = counting down
  logic [WIDTH-1:0]          period_q;
  logic [CHANNELS*WIDTH-1:0] duty_q;
  logic                      mode_q;
  logic [WIDTH-1:0]          period_s;
  logic [CHANNELS*WIDTH-1:0] duty_s;
  logic                      mode_s;
  logic                      pending;

  logic                      at_top;
  logic                      boundary;
  logic                      xfer;
  logic [WIDTH-1:0]          cnt_next;
  logic                      dir_next;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    at_top   = (cnt == period_q);
    boundary = 1'b0;
    cnt_next = cnt + WIDTH'(1);
    dir_next = dir;

    // The turning point of a center-aligned count is treated as already descending,
    // so period_q == 1 yields the two-cycle sequence 0,1.
    if (period_q == '0)
      boundary = 1'b1;
    else if (mode_q)
      boundary = (dir || at_top) && (cnt <= WIDTH'(1));
    else
      boundary = at_top;

    xfer = pending && (boundary || !en);

    if (!en || boundary) begin
      cnt_next = '0;
      dir_next = 1'b0;
    end else if (mode_q && (dir || at_top)) begin
      cnt_next = cnt - WIDTH'(1);
      dir_next = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      dir        <= 1'b0;
      period_q   <= '0;
      duty_q     <= '0;
      mode_q     <= 1'b0;
      period_s   <= '0;
      duty_s     <= '0;
      mode_s     <= 1'b0;
      pending    <= 1'b0;
      pwm_out    <= '0;
      period_end <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      dir        <= dir_next;
      period_end <= en && boundary;
      load_ack   <= xfer;

      // Transfer uses the shadow as it stood before this edge; a coincident load waits.
      if (xfer) begin
        period_q <= period_s;
        duty_q   <= duty_s;
        mode_q   <= mode_s;
      end
      if (load) begin
        period_s <= period;
        duty_s   <= duty;
        mode_s   <= center_mode;
      end
      pending <= load || (pending && !xfer);

      for (int i = 0; i < CHANNELS; i++)
        pwm_out[i] <= en && (cnt < duty_q[i*WIDTH +: WIDTH]);
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboard bench for pwm_multichannel: a phase-based reference model predicts each
// cycle's outputs into a queue, and an independent monitor compares them.
module tb_pwm_multichannel;
  localparam int W = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           load = 1'b0;
  logic           center_mode = 1'b0;
  logic [W-1:0]   period = '0;
  logic [C*W-1:0] duty = '0;
  logic [C-1:0]   pwm_out;
  logic           period_end;
  logic           load_ack;

  pwm_multichannel #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .center_mode(center_mode),
    .period(period), .duty(duty), .pwm_out(pwm_out),
    .period_end(period_end), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [C-1:0] pwm;
    logic         pe;
    logic         ack;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference state: position within the current period rather than a counter/direction pair.
  int             m_p = 0;
  logic [W-1:0]   a_per = '0, s_per = '0;
  logic           a_mode = 1'b0, s_mode = 1'b0;
  logic [C*W-1:0] a_duty = '0, s_duty = '0;
  logic           m_pend = 1'b0;

  // Defaults reused by idle cycles.
  logic           g_mode = 1'b0;
  logic [W-1:0]   g_per = '0;
  logic [C*W-1:0] g_duty = '0;

  function automatic int len_of(input logic [W-1:0] per, input logic mode);
    if (per == 0) return 1;
    return mode ? 2 * int'(per) : int'(per) + 1;
  endfunction

  function automatic int cnt_of(input int p, input logic [W-1:0] per, input logic mode);
    if (!mode || p <= int'(per)) return p;
    return 2 * int'(per) - p;
  endfunction

  function automatic int cur_cnt();
    return cnt_of(m_p, a_per, a_mode);
  endfunction

  function automatic int cur_len();
    return len_of(a_per, a_mode);
  endfunction

  task automatic tick(input logic r, input logic e, input logic l, input logic m,
                      input logic [W-1:0] per, input logic [C*W-1:0] d);
    exp_t x;
    int   c;
    logic bnd;
    logic xf;
    @(negedge clk);
    rst = r; en = e; load = l; center_mode = m; period = per; duty = d;
    x = '0;
    if (r) begin
      m_p = 0; a_per = '0; s_per = '0; a_mode = 1'b0; s_mode = 1'b0;
      a_duty = '0; s_duty = '0; m_pend = 1'b0;
    end else begin
      c   = cur_cnt();
      bnd = (m_p == cur_len() - 1);
      for (int i = 0; i < C; i++)
        x.pwm[i] = e && (c < int'(a_duty[i*W +: W]));
      x.pe  = e && bnd;
      xf    = m_pend && (bnd || !e);
      x.ack = xf;
      m_p   = (!e || bnd) ? 0 : m_p + 1;
      if (xf) begin
        a_per = s_per; a_mode = s_mode; a_duty = s_duty;
      end
      m_pend = l || (m_pend && !xf);
      if (l) begin
        s_per = per; s_mode = m; s_duty = d;
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic run(input int n, input logic e);
    for (int i = 0; i < n; i++) tick(1'b0, e, 1'b0, g_mode, g_per, g_duty);
  endtask

  task automatic do_load(input logic e, input logic m, input logic [W-1:0] per,
                         input logic [C*W-1:0] d);
    g_mode = m; g_per = per; g_duty = d;
    tick(1'b0, e, 1'b1, m, per, d);
  endtask

  // Monitor: one comparison per clock for which a prediction exists.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        total++;
        if ({pwm_out, period_end, load_ack} !== x) begin
          bad++;
          $display("FAIL outputs t=%0t: got pwm=%b pe=%b ack=%b, want pwm=%b pe=%b ack=%b",
                   $time, pwm_out, period_end, load_ack, x.pwm, x.pe, x.ack);
        end
      end
    end
  end

  initial begin
    // Reset state.
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    run(3, 1'b1);

    // Edge mode, period 9, duties 3,0,10,5.
    do_load(1'b1, 1'b0, 8'd9, {8'd5, 8'd10, 8'd0, 8'd3});
    run(35, 1'b1);

    // Mid-period update at cnt == 5.
    for (int i = 0; i < 40 && cur_cnt() != 5; i++) run(1, 1'b1);
    do_load(1'b1, 1'b0, 8'd9, {8'd5, 8'd10, 8'd0, 8'd7});
    run(25, 1'b1);

    // Load coincident with the boundary.
    for (int i = 0; i < 40 && m_p != cur_len() - 1; i++) run(1, 1'b1);
    do_load(1'b1, 1'b0, 8'd9, {8'd9, 8'd2, 8'd4, 8'd1});
    run(25, 1'b1);

    // Center mode, period 4, ch0 duty 2.
    do_load(1'b1, 1'b1, 8'd4, {8'd5, 8'd4, 8'd0, 8'd2});
    run(30, 1'b1);

    // Reset mid-run with en held high.
    run(3, 1'b1);
    tick(1'b1, 1'b1, 1'b0, g_mode, g_per, g_duty);
    tick(1'b1, 1'b1, 1'b0, g_mode, g_per, g_duty);
    run(4, 1'b1);
    do_load(1'b1, 1'b0, 8'd9, {8'd5, 8'd10, 8'd0, 8'd3});
    run(14, 1'b1);

    // Enable low mid-period, with a load accepted while disabled.
    run(2, 1'b0);
    do_load(1'b0, 1'b0, 8'd6, {8'd1, 8'd2, 8'd7, 8'd4});
    run(2, 1'b0);
    run(16, 1'b1);

    // Degenerate period 0 with duty 1.
    do_load(1'b1, 1'b0, 8'd0, {8'd1, 8'd1, 8'd1, 8'd1});
    run(10, 1'b1);
    do_load(1'b1, 1'b1, 8'd0, {8'd1, 8'd0, 8'd1, 8'd0});
    run(10, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic           r, e, l, m;
      logic [W-1:0]   per;
      logic [C*W-1:0] d;
      r   = ($urandom_range(0, 99) == 0);
      e   = ($urandom_range(0, 7) != 0);
      l   = ($urandom_range(0, 15) == 0);
      m   = 1'(($urandom & 32'h1));
      per = W'($urandom_range(0, 12));
      for (int k = 0; k < C; k++) d[k*W +: W] = W'($urandom_range(0, 14));
      tick(r, e, l, m, per, d);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
